// File: rtl/fb16_conv_sched.sv
// Round-robin scheduler sharing one FB16_to_FD27 converter between NCH requesters.
// Grants a channel, starts the converter, waits for a rising ok (with watchdog) and returns the tagged result.
module fb16_conv_sched #(
    parameter int NCH = 4,
    parameter int CHW = 2,
    parameter int TMO = 63
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NCH-1:0]    req_i,
    input  logic [16*NCH-1:0] din_i,
    output logic [NCH-1:0]    ack_o,
    output logic              conv_st_o,
    output logic [15:0]       conv_fbi_o,
    input  logic              conv_ok_i,
    input  logic [26:0]       conv_fdo_i,
    output logic [26:0]       res_o,
    output logic [CHW-1:0]    res_ch_o,
    output logic              res_vld_o,
    output logic              err_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [7:0] TMO_LAST = 8'(TMO - 1);

    state_e         state_q, state_d;
    logic [CHW-1:0] ptr_q, ptr_d;
    logic [7:0]     timer_q, timer_d;
    logic           ok_q;
    logic [NCH-1:0] ack_q, ack_d;
    logic           conv_st_q, conv_st_d;
    logic [15:0]    conv_fbi_q, conv_fbi_d;
    logic [26:0]    res_q, res_d;
    logic [CHW-1:0] res_ch_q, res_ch_d;
    logic           res_vld_q, res_vld_d;
    logic           err_q, err_d;
    logic           busy_q, busy_d;

    logic           ok_rise_s;
    logic           grant_vld_s;
    logic [CHW-1:0] grant_idx_s;
    logic [CHW-1:0] cand_s;

    // A level-high ok from a previous conversion must not count; only a fresh rise does.
    assign ok_rise_s = conv_ok_i & ~ok_q;

    // Round-robin search: ptr+1, ptr+2, ... wrapping, with ptr itself checked last.
    always_comb begin
        grant_vld_s = 1'b0;
        grant_idx_s = ptr_q;
        cand_s      = ptr_q;
        for (int i = 1; i <= NCH; i++) begin
            cand_s = ptr_q + i[CHW-1:0];
            if (!grant_vld_s && req_i[cand_s]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = cand_s;
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Next-state and registered-output logic of the scheduler FSM.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        timer_d    = timer_q;
        ack_d      = {NCH{1'b0}};
        conv_st_d  = 1'b0;
        conv_fbi_d = conv_fbi_q;
        res_d      = res_q;
        res_ch_d   = res_ch_q;
        res_vld_d  = 1'b0;
        err_d      = 1'b0;
        busy_d     = busy_q;
        case (state_q)
            S_IDLE: begin
                if (grant_vld_s) begin
                    ptr_d      = grant_idx_s;
                    conv_fbi_d = din_i[{grant_idx_s, 4'b0000} +: 16];
                    ack_d      = {{(NCH-1){1'b0}}, 1'b1} << grant_idx_s;
                    conv_st_d  = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = S_START;
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_START: begin
                timer_d = 8'd0;
                busy_d  = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                busy_d = 1'b1;
                // A rise on the final cycle still wins over the timeout.
                if (ok_rise_s) begin
                    res_d     = conv_fdo_i;
                    res_ch_d  = ptr_q;
                    res_vld_d = 1'b1;
                    state_d   = S_DONE;
                end else if (timer_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            ptr_q      <= CHW'(NCH - 1);
            timer_q    <= 8'd0;
            ok_q       <= 1'b0;
            ack_q      <= {NCH{1'b0}};
            conv_st_q  <= 1'b0;
            conv_fbi_q <= 16'd0;
            res_q      <= 27'd0;
            res_ch_q   <= {CHW{1'b0}};
            res_vld_q  <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            timer_q    <= timer_d;
            ok_q       <= conv_ok_i;
            ack_q      <= ack_d;
            conv_st_q  <= conv_st_d;
            conv_fbi_q <= conv_fbi_d;
            res_q      <= res_d;
            res_ch_q   <= res_ch_d;
            res_vld_q  <= res_vld_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign ack_o      = ack_q;
    assign conv_st_o  = conv_st_q;
    assign conv_fbi_o = conv_fbi_q;
    assign res_o      = res_q;
    assign res_ch_o   = res_ch_q;
    assign res_vld_o  = res_vld_q;
    assign err_o      = err_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_fb16_conv_sched.sv
// Self-checking bench for fb16_conv_sched: vector table, hand-written corner sequences
// and randomized traffic against a round-robin/BCD reference model with a converter stand-in.
module tb_fb16_conv_sched;

    localparam int NCH = 4;
    localparam int CHW = 2;
    localparam int TMO = 63;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [NCH-1:0]    req_i;
    logic [16*NCH-1:0] din_i;
    logic [NCH-1:0]    ack_o;
    logic              conv_st_o;
    logic [15:0]       conv_fbi_o;
    logic              conv_ok_i;
    logic [26:0]       conv_fdo_i;
    logic [26:0]       res_o;
    logic [CHW-1:0]    res_ch_o;
    logic              res_vld_o;
    logic              err_o;
    logic              busy_o;

    fb16_conv_sched #(.NCH(NCH), .CHW(CHW), .TMO(TMO)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .din_i      (din_i),
        .ack_o      (ack_o),
        .conv_st_o  (conv_st_o),
        .conv_fbi_o (conv_fbi_o),
        .conv_ok_i  (conv_ok_i),
        .conv_fdo_i (conv_fdo_i),
        .res_o      (res_o),
        .res_ch_o   (res_ch_o),
        .res_vld_o  (res_vld_o),
        .err_o      (err_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          conv_dly = 5;
    bit          conv_static = 1'b0;
    int          mptr = NCH - 1;
    logic [26:0] exp_last_res = 27'd0;
    int          exp_last_ch = 0;

    typedef struct {
        logic [3:0]  req;
        int          dly;
        bit          to;
        int          ch;
        logic [15:0] fbi;
        logic [26:0] res;
    } vec_t;

    vec_t tab[15];

    function automatic logic [26:0] bcd(input logic [15:0] v);
        int n;
        logic [26:0] r;
        n = int'(v);
        r = 27'd0;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    function automatic int rr_pick(input int p, input logic [3:0] r);
        for (int i = 1; i <= NCH; i++) begin
            if (r[(p + i) % NCH]) return (p + i) % NCH;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s/%s: got %0h expected %0h", tag, name, act, exp);
        end
    endtask

    // Converter stand-in: drops ok on st, raises it conv_dly cycles later with the BCD of the operand.
    initial begin
        int k;
        logic [15:0] op;
        k = -1;
        op = 16'd0;
        conv_ok_i = 1'b0;
        conv_fdo_i = 27'd0;
        forever begin
            @(posedge clk_i); #1;
            if (conv_st_o) begin
                k = 0;
                op = conv_fbi_o;
                if (!conv_static) conv_ok_i = 1'b0;
            end else if (k >= 0) begin
                k++;
            end
            if (conv_static) begin
                conv_ok_i = 1'b1;
            end else if (k >= 0 && conv_dly >= 0 && k == conv_dly) begin
                conv_ok_i = 1'b1;
                conv_fdo_i = bcd(op);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk(tag, "ack", 32'(ack_o), 32'd0);
        chk(tag, "conv_st", 32'(conv_st_o), 32'd0);
        chk(tag, "conv_fbi", 32'(conv_fbi_o), 32'd0);
        chk(tag, "res", 32'(res_o), 32'd0);
        chk(tag, "res_ch", 32'(res_ch_o), 32'd0);
        chk(tag, "res_vld", 32'(res_vld_o), 32'd0);
        chk(tag, "err", 32'(err_o), 32'd0);
        chk(tag, "busy", 32'(busy_o), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        req_i = 4'b0000;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        check_all_zero(tag);
        mptr = NCH - 1;
        exp_last_res = 27'd0;
        exp_last_ch = 0;
    endtask

    task automatic run_txn(input logic [3:0] r, input int dly, input bit exp_to, input int exp_k,
                           input logic [15:0] exp_fbi, input logic [26:0] exp_res, input string tag);
        int w;
        int c;
        bit done;
        logic [16*NCH-1:0] din_sav;
        conv_dly = dly;
        req_i = r;
        w = 0;
        do begin
            @(posedge clk_i); #1;
            w++;
        end while (ack_o == 4'b0000 && w < 8);
        chk(tag, "grant_wait", 32'(w), 32'd1);
        if (ack_o == 4'b0000) begin
            req_i = 4'b0000;
            return;
        end
        chk(tag, "ack", 32'(ack_o), 32'(4'b0001 << exp_k));
        chk(tag, "conv_st", 32'(conv_st_o), 32'd1);
        chk(tag, "busy_start", 32'(busy_o), 32'd1);
        chk(tag, "conv_fbi", 32'(conv_fbi_o), 32'(exp_fbi));
        // Inputs changing while busy must be ignored.
        din_sav = din_i;
        din_i = ~din_i;
        req_i = 4'($urandom);
        c = 0;
        done = 1'b0;
        while (!done && c < 80) begin
            @(posedge clk_i); #1;
            c++;
            if (res_vld_o || err_o) begin
                done = 1'b1;
            end else if (c == 1) begin
                chk(tag, "st_pulse", 32'({ack_o, conv_st_o}), 32'd0);
            end
        end
        if (exp_to) begin
            chk(tag, "err", 32'(err_o), 32'd1);
            chk(tag, "err_cycle", 32'(c), 32'(TMO + 1));
            chk(tag, "no_vld", 32'(res_vld_o), 32'd0);
            chk(tag, "res_hold", 32'(res_o), 32'(exp_last_res));
            chk(tag, "res_ch_hold", 32'(res_ch_o), 32'(exp_last_ch));
            chk(tag, "busy_err", 32'(busy_o), 32'd0);
        end else begin
            chk(tag, "res_vld", 32'(res_vld_o), 32'd1);
            chk(tag, "latency", 32'(c), 32'(dly + 1));
            chk(tag, "res", 32'(res_o), 32'(exp_res));
            chk(tag, "res_ch", 32'(res_ch_o), 32'(exp_k));
            chk(tag, "no_err", 32'(err_o), 32'd0);
            chk(tag, "busy_done", 32'(busy_o), 32'd1);
            exp_last_res = exp_res;
            exp_last_ch = exp_k;
        end
        chk(tag, "fbi_held", 32'(conv_fbi_o), 32'(exp_fbi));
        din_i = din_sav;
        req_i = 4'b0000;
        @(posedge clk_i); #1;
        chk(tag, "post_pulses", 32'({res_vld_o, err_o, busy_o, ack_o}), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [3:0] r;
        int k;
        int d;
        rst_i = 1'b1;
        req_i = 4'b0000;
        din_i = '0;

        tab[0]  = '{4'b1111,  5, 1'b0, 0, 16'd1234,  27'h001234};
        tab[1]  = '{4'b1111,  1, 1'b0, 1, 16'd65535, 27'h065535};
        tab[2]  = '{4'b1111,  9, 1'b0, 2, 16'd0,     27'h000000};
        tab[3]  = '{4'b1111, 30, 1'b0, 3, 16'd40000, 27'h040000};
        tab[4]  = '{4'b1111,  3, 1'b0, 0, 16'd1234,  27'h001234};
        tab[5]  = '{4'b0101,  4, 1'b0, 2, 16'd0,     27'h000000};
        tab[6]  = '{4'b0101,  2, 1'b0, 0, 16'd1234,  27'h001234};
        tab[7]  = '{4'b0101, 12, 1'b0, 2, 16'd0,     27'h000000};
        tab[8]  = '{4'b0101,  7, 1'b0, 0, 16'd1234,  27'h001234};
        tab[9]  = '{4'b1000, -1, 1'b1, 3, 16'd40000, 27'h000000};
        tab[10] = '{4'b0010,  8, 1'b0, 1, 16'd65535, 27'h065535};
        tab[11] = '{4'b1001, 63, 1'b0, 3, 16'd40000, 27'h040000};
        tab[12] = '{4'b0001, 64, 1'b1, 0, 16'd1234,  27'h000000};
        tab[13] = '{4'b0110,  6, 1'b0, 1, 16'd65535, 27'h065535};
        tab[14] = '{4'b1100, 10, 1'b0, 2, 16'd0,     27'h000000};

        // Reset state and first transaction.
        do_reset("reset");
        din_i[15:0] = 16'h4D3A;
        run_txn(4'b0001, 17, 1'b0, 0, 16'h4D3A, 27'h019770, "t1");

        // Table: round-robin order, timeout and final-cycle boundaries.
        do_reset("reset2");
        din_i = {16'd40000, 16'd0, 16'd65535, 16'd1234};
        foreach (tab[i]) begin
            run_txn(tab[i].req, tab[i].dly, tab[i].to, tab[i].ch, tab[i].fbi, tab[i].res,
                    $sformatf("tab%0d", i));
        end

        // Reset in the middle of WAIT, then pointer restarts from NCH-1.
        conv_dly = -1;
        req_i = 4'b0100;
        k = 0;
        do begin
            @(posedge clk_i); #1;
            k++;
        end while (ack_o == 4'b0000 && k < 8);
        chk("midrst", "ack", 32'(ack_o), 32'b0100);
        req_i = 4'b0000;
        repeat (5) begin
            @(posedge clk_i); #1;
        end
        chk("midrst", "busy_wait", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        check_all_zero("midrst");
        exp_last_res = 27'd0;
        exp_last_ch = 0;
        run_txn(4'b1010, 5, 1'b0, 1, 16'd65535, 27'h065535, "midrst_a");
        run_txn(4'b1010, 5, 1'b0, 3, 16'd40000, 27'h040000, "midrst_b");

        // Static-high ok must time out; a proper drop-then-rise completes.
        conv_static = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        run_txn(4'b0001, -1, 1'b1, 0, 16'd1234, 27'h000000, "static");
        conv_static = 1'b0;
        run_txn(4'b0010, 2, 1'b0, 1, 16'd65535, 27'h065535, "drop2");

        // Randomized traffic against the round-robin / BCD reference.
        do_reset("reset3");
        for (int t = 0; t < 40; t++) begin
            for (int c = 0; c < NCH; c++) din_i[16*c +: 16] = 16'($urandom);
            r = 4'($urandom);
            if (r == 4'b0000) begin
                req_i = 4'b0000;
                repeat (3) begin
                    @(posedge clk_i); #1;
                    chk("rnd_idle", "ack_busy", 32'({ack_o, busy_o}), 32'd0);
                end
            end else begin
                k = rr_pick(mptr, r);
                d = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, 63));
                run_txn(r, d, d < 0, k, din_i[16*k +: 16], bcd(din_i[16*k +: 16]),
                        $sformatf("rnd%0d", t));
                mptr = k;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
